// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: buffers dispatched instructions with a dependency
// matrix and issues one dependency-free slot per cycle, round-robin.
module esm_issue_scheduler #(
    parameter int INSTR_W = 32,
    parameter int BS      = 16,
    localparam int IDX_W  = $clog2(BS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [BS-1:0]      in_dep,
    output logic [IDX_W-1:0]   in_idx,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [IDX_W-1:0]   issue_idx,
    input  logic               done_valid,
    input  logic [IDX_W-1:0]   done_idx,
    output logic [IDX_W:0]     count,
    output logic               full,
    output logic               empty
);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_SEL, S_ISSUED} slot_state_t;

    slot_state_t        state   [BS];
    logic [BS-1:0]      dep     [BS];
    logic [INSTR_W-1:0] payload [BS];
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W:0]     count_q;

    logic [BS-1:0]    free_vec;
    logic [BS-1:0]    ready_vec;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_found;
    logic [BS-1:0]    new_row;
    logic             alloc;
    logic             done_acc;
    logic             handoff;
    logic             load;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < BS; i++) begin
            free_vec[i]  = (state[i] == S_FREE);
            ready_vec[i] = (state[i] == S_WAIT) && (dep[i] == '0);
        end

        alloc_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = IDX_W'(i);
        end

        // Round-robin search starting at rr_ptr; index arithmetic wraps naturally.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < BS; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!sel_found && ready_vec[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign full     = (count_q == (IDX_W+1)'(BS));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !flush;
    assign in_idx   = alloc_idx;
    assign count    = count_q;

    assign alloc    = in_valid && in_ready;
    assign done_acc = done_valid && !flush && (state[done_idx] == S_ISSUED);
    assign handoff  = issue_valid && issue_ready;
    assign load     = !issue_valid || issue_ready;

    // A producer completing in the same cycle never becomes a dependency of the new row.
    always_comb begin
        new_row            = in_dep & ~free_vec;
        new_row[alloc_idx] = 1'b0;
        if (done_valid) new_row[done_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BS; i++) begin
                state[i]   <= S_FREE;
                dep[i]     <= '0;
                payload[i] <= '0;
            end
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_idx   <= '0;
            rr_ptr      <= '0;
            count_q     <= '0;
        end else if (flush) begin
            for (int i = 0; i < BS; i++) begin
                state[i] <= S_FREE;
                dep[i]   <= '0;
            end
            issue_valid <= 1'b0;
            rr_ptr      <= '0;
            count_q     <= '0;
        end else begin
            if (done_acc) begin
                for (int i = 0; i < BS; i++) dep[i][done_idx] <= 1'b0;
                state[done_idx] <= S_FREE;
            end
            if (handoff) state[issue_idx] <= S_ISSUED;
            if (load) begin
                if (sel_found) begin
                    state[sel_idx] <= S_SEL;
                    issue_valid    <= 1'b1;
                    issue_instr    <= payload[sel_idx];
                    issue_idx      <= sel_idx;
                    rr_ptr         <= sel_idx + IDX_W'(1);
                end else begin
                    issue_valid <= 1'b0;
                end
            end
            if (alloc) begin
                state[alloc_idx]   <= S_WAIT;
                dep[alloc_idx]     <= new_row;
                payload[alloc_idx] <= in_instr;
            end
            count_q <= count_q + (IDX_W+1)'(alloc) - (IDX_W+1)'(done_acc);
        end
    end

endmodule
